// File: rtl/tt_dpll_pkg.sv
// ---------------------------------------------------------------------------
// tt_dpll_pkg
// Shared definitions for the DPLL lock-detect slice.
//   lock_state_e  : lock detector state encoding (value 3 is illegal)
//   LOCK_CNT_W    : width of every lock-detect counter
//   LOCK_SCAN_LEN : length of the lock detector's scan chain segment
// ---------------------------------------------------------------------------
package tt_dpll_pkg;

  localparam int LOCK_CNT_W    = 8;
  localparam int LOCK_SCAN_LEN = 35;

  typedef enum logic [1:0] {
    UNLOCKED  = 2'd0,
    ACQUIRING = 2'd1,
    LOCKED    = 2'd2
  } lock_state_e;

endpackage

// File: rtl/tt_lock_detect_if.sv
// ---------------------------------------------------------------------------
// tt_lock_detect_if
// Functional signal bundle between the PFD/DPLL control side and the lock
// detector. Signal names keep the detector's point of view (i_ = into the
// detector, o_ = out of the detector).
//   i_up, i_down   : PFD pulses, synchronous to the generated clock
//   i_clear_loss   : synchronous clear of the loss counter
//   o_locked       : detector is in LOCKED
//   o_lock_lost    : one-cycle pulse on LOCKED -> UNLOCKED
//   o_loss_count   : saturating count of lock losses
//   o_state        : raw state register
// Modports: master = control side, slave = lock detector.
// ---------------------------------------------------------------------------
interface tt_lock_detect_if;
  import tt_dpll_pkg::*;

  logic                  i_up;
  logic                  i_down;
  logic                  i_clear_loss;
  logic                  o_locked;
  logic                  o_lock_lost;
  logic [LOCK_CNT_W-1:0] o_loss_count;
  logic [1:0]            o_state;

  modport master (
    output i_up, i_down, i_clear_loss,
    input  o_locked, o_lock_lost, o_loss_count, o_state
  );

  modport slave (
    input  i_up, i_down, i_clear_loss,
    output o_locked, o_lock_lost, o_loss_count, o_state
  );

endinterface

// File: rtl/tt_sat_counter.sv
// ---------------------------------------------------------------------------
// tt_sat_counter
// Up-counter with parallel load, synchronous clear and optional saturation.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (highest priority, used for scan shifting)
//   load_val   : value to load
//   clr        : synchronous clear; a simultaneous inc leaves the count at 1
//   inc        : increment request
//   count      : current count
// Parameters: WIDTH = counter width, SATURATE = 1 holds at all-ones,
// 0 lets the counter wrap.
// ---------------------------------------------------------------------------
module tt_sat_counter #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic at_max;

  assign at_max = SATURATE && (&count);

  // Load beats clear beats increment. A clear that coincides with an
  // increment means the event being counted happened after the clear,
  // so it must still be recorded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (clr) begin
      count <= inc ? WIDTH'(1) : '0;
    end else if (inc && !at_max) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/tt_lock_detect.sv
// ---------------------------------------------------------------------------
// tt_lock_detect
// Hysteretic DPLL lock detector. Lock is declared after LOCK_CYCLES
// consecutive quiet PFD cycles; once locked, lock is dropped only when
// UNLOCK_ERRS error cycles land inside one WINDOW-cycle window. Lock losses
// are counted in a saturating 8-bit counter. All state sits on a 35-bit scan
// segment {state, quiet_cnt, win_cnt, err_cnt, loss_cnt, lost_pulse}.
//   i_clk_gen  : generated clock, all state updates on its rising edge
//   i_rst_n    : asynchronous active-low reset
//   bus        : tt_lock_detect_if.slave (PFD pulses, clear, status)
//   i_scan_en  : scan shift enable, overrides all functional updates
//   i_scan_in  : scan data in (enters at the state MSB)
//   o_scan_out : scan data out (the lost_pulse bit)
// ---------------------------------------------------------------------------
module tt_lock_detect
  import tt_dpll_pkg::*;
#(
  parameter int LOCK_CYCLES = 64,
  parameter int WINDOW      = 32,
  parameter int UNLOCK_ERRS = 4
) (
  input  logic              i_clk_gen,
  input  logic              i_rst_n,
  tt_lock_detect_if.slave   bus,
  input  logic              i_scan_en,
  input  logic              i_scan_in,
  output logic              o_scan_out
);

  // Refuse to build with parameters the 8-bit counters cannot honour.
  if (LOCK_CYCLES < 1 || LOCK_CYCLES > 255) begin : g_bad_lock_cycles
    $fatal(1, "tt_lock_detect: LOCK_CYCLES must be 1..255");
  end
  if (WINDOW < 1 || WINDOW > 255) begin : g_bad_window
    $fatal(1, "tt_lock_detect: WINDOW must be 1..255");
  end
  if (UNLOCK_ERRS < 1 || UNLOCK_ERRS > WINDOW) begin : g_bad_unlock_errs
    $fatal(1, "tt_lock_detect: UNLOCK_ERRS must be 1..WINDOW");
  end

  localparam logic [1:0] ST_UNLOCKED  = UNLOCKED;
  localparam logic [1:0] ST_ACQUIRING = ACQUIRING;
  localparam logic [1:0] ST_LOCKED    = LOCKED;

  localparam logic [LOCK_CNT_W-1:0] LOCK_LAST = LOCK_CNT_W'(LOCK_CYCLES - 1);
  localparam logic [LOCK_CNT_W-1:0] WIN_LAST  = LOCK_CNT_W'(WINDOW - 1);
  localparam logic [LOCK_CNT_W-1:0] ERR_LIMIT = LOCK_CNT_W'(UNLOCK_ERRS);

  logic [1:0]               state_q, state_d;
  logic [LOCK_CNT_W-1:0]    quiet_q, quiet_d;
  logic [LOCK_CNT_W-1:0]    win_q, win_d;
  logic [LOCK_CNT_W-1:0]    err_q, err_d;
  logic [LOCK_CNT_W-1:0]    err_inc;
  logic [LOCK_CNT_W-1:0]    loss_cnt;
  logic                     lost_q;
  logic                     is_quiet;
  logic                     loss_event;
  logic                     illegal_state;
  logic [LOCK_SCAN_LEN-1:0] chain_q;
  logic [LOCK_SCAN_LEN-1:0] chain_shift;

  assign is_quiet = !bus.i_up && !bus.i_down;
  assign err_inc  = err_q + 8'd1;

  // Next-state and counter logic. UNLOCKED/ACQUIRING only track the run of
  // quiet cycles. In LOCKED the loss test comes before the window rollover,
  // so an error on the last cycle of a window still counts toward that
  // window. The unused encoding 3 recovers to UNLOCKED with everything
  // cleared.
  always_comb begin
    state_d       = state_q;
    quiet_d       = quiet_q;
    win_d         = win_q;
    err_d         = err_q;
    loss_event    = 1'b0;
    illegal_state = 1'b0;
    case (state_q)
      ST_UNLOCKED: begin
        if (is_quiet) begin
          if (LOCK_LAST == 8'd0) begin
            state_d = ST_LOCKED;
            quiet_d = '0;
            win_d   = '0;
            err_d   = '0;
          end else begin
            state_d = ST_ACQUIRING;
            quiet_d = 8'd1;
          end
        end else begin
          quiet_d = '0;
        end
      end
      ST_ACQUIRING: begin
        if (!is_quiet) begin
          state_d = ST_UNLOCKED;
          quiet_d = '0;
        end else if (quiet_q == LOCK_LAST) begin
          state_d = ST_LOCKED;
          quiet_d = '0;
          win_d   = '0;
          err_d   = '0;
        end else begin
          quiet_d = quiet_q + 8'd1;
        end
      end
      ST_LOCKED: begin
        if (!is_quiet && (err_inc == ERR_LIMIT)) begin
          state_d    = ST_UNLOCKED;
          quiet_d    = '0;
          win_d      = '0;
          err_d      = '0;
          loss_event = 1'b1;
        end else if (win_q == WIN_LAST) begin
          win_d = '0;
          err_d = '0;
        end else begin
          win_d = win_q + 8'd1;
          if (!is_quiet) begin
            err_d = err_inc;
          end
        end
      end
      default: begin
        state_d       = ST_UNLOCKED;
        quiet_d       = '0;
        win_d         = '0;
        err_d         = '0;
        illegal_state = 1'b1;
      end
    endcase
  end

  // Scan view of the state; bit 0 is lost_pulse so it doubles as scan out.
  assign chain_q     = {state_q, quiet_q, win_q, err_q, loss_cnt, lost_q};
  assign chain_shift = {i_scan_in, chain_q[LOCK_SCAN_LEN-1:1]};

  // State register. Scan shifting takes priority over every functional
  // update so the chain can be loaded and unloaded without disturbance.
  always_ff @(posedge i_clk_gen or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_UNLOCKED;
      quiet_q <= '0;
      win_q   <= '0;
      err_q   <= '0;
      lost_q  <= 1'b0;
    end else if (i_scan_en) begin
      state_q <= chain_shift[34:33];
      quiet_q <= chain_shift[32:25];
      win_q   <= chain_shift[24:17];
      err_q   <= chain_shift[16:9];
      lost_q  <= chain_shift[0];
    end else begin
      state_q <= state_d;
      quiet_q <= quiet_d;
      win_q   <= win_d;
      err_q   <= err_d;
      lost_q  <= loss_event;
    end
  end

  // Loss counter; it also forms the chain bits [8:1]. Clear requests are
  // masked during scan because the load path has priority inside the counter.
  tt_sat_counter #(
    .WIDTH    (LOCK_CNT_W),
    .SATURATE (1'b1)
  ) u_loss_cnt (
    .clk      (i_clk_gen),
    .rst_n    (i_rst_n),
    .load     (i_scan_en),
    .load_val (chain_shift[8:1]),
    .clr      (bus.i_clear_loss || illegal_state),
    .inc      (loss_event),
    .count    (loss_cnt)
  );

  assign bus.o_locked     = (state_q == ST_LOCKED);
  assign bus.o_lock_lost  = lost_q;
  assign bus.o_loss_count = loss_cnt;
  assign bus.o_state      = state_q;
  assign o_scan_out       = chain_q[0];

endmodule

// File: tb/tb_tt_lock_detect.sv
// ---------------------------------------------------------------------------
// tb_tt_lock_detect
// Self-checking bench for tt_lock_detect with default parameters
// (LOCK_CYCLES=64, WINDOW=32, UNLOCK_ERRS=4). A behavioural model predicts
// the outputs of every cycle; predictions are queued when stimulus is driven
// and popped/compared once the DUT has clocked. Directed checks against
// fixed values cover the lock/unlock boundaries, saturation and scan.
// ---------------------------------------------------------------------------
module tb_tt_lock_detect;
  import tt_dpll_pkg::*;

  localparam int LOCK_CYCLES = 64;
  localparam int WINDOW      = 32;
  localparam int UNLOCK_ERRS = 4;

  typedef struct packed {
    logic       locked;
    logic       lock_lost;
    logic [7:0] loss_count;
    logic [1:0] state;
    logic       scan_out;
  } expect_t;

  logic  clk_gen = 1'b0;
  logic  rst_n   = 1'b1;
  logic  scan_en = 1'b0;
  logic  scan_in = 1'b0;
  logic  scan_out;

  expect_t sb_q[$];
  int      compare_count  = 0;
  int      mismatch_count = 0;
  string   phase = "init";

  logic [1:0] m_state;
  logic [7:0] m_quiet, m_win, m_err, m_loss;
  logic       m_lost;

  tt_lock_detect_if bus ();

  tt_lock_detect #(
    .LOCK_CYCLES (LOCK_CYCLES),
    .WINDOW      (WINDOW),
    .UNLOCK_ERRS (UNLOCK_ERRS)
  ) dut (
    .i_clk_gen  (clk_gen),
    .i_rst_n    (rst_n),
    .bus        (bus),
    .i_scan_en  (scan_en),
    .i_scan_in  (scan_in),
    .o_scan_out (scan_out)
  );

  // Free-running generated clock, period 10
  always #5 clk_gen = ~clk_gen;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s/%s: observed %0h expected %0h", phase, tag,
               observed, expected);
    end
  endtask

  task automatic modelReset();
    m_state = 2'd0;
    m_quiet = 8'd0;
    m_win   = 8'd0;
    m_err   = 8'd0;
    m_loss  = 8'd0;
    m_lost  = 1'b0;
  endtask

  // Reference behaviour of one rising edge, written from the block's
  // description of each state
  task automatic modelStep(input logic up, input logic down, input logic clr,
                           input logic sen, input logic sin);
    logic [34:0] chain;
    logic        quiet_c;
    logic        loss_ev;
    logic        was_illegal;
    if (sen) begin
      chain = {m_state, m_quiet, m_win, m_err, m_loss, m_lost};
      chain = {sin, chain[34:1]};
      {m_state, m_quiet, m_win, m_err, m_loss, m_lost} = chain;
    end else begin
      quiet_c     = !up && !down;
      loss_ev     = 1'b0;
      was_illegal = 1'b0;
      case (m_state)
        2'd0: begin
          if (quiet_c) begin
            m_state = 2'd1;
            m_quiet = 8'd1;
          end else begin
            m_quiet = 8'd0;
          end
        end
        2'd1: begin
          if (!quiet_c) begin
            m_state = 2'd0;
            m_quiet = 8'd0;
          end else if (m_quiet == LOCK_CYCLES - 1) begin
            m_state = 2'd2;
            m_quiet = 8'd0;
            m_win   = 8'd0;
            m_err   = 8'd0;
          end else begin
            m_quiet++;
          end
        end
        2'd2: begin
          if (!quiet_c && (m_err + 1 == UNLOCK_ERRS)) begin
            m_state = 2'd0;
            m_quiet = 8'd0;
            m_win   = 8'd0;
            m_err   = 8'd0;
            loss_ev = 1'b1;
          end else begin
            if (!quiet_c) m_err++;
            if (m_win == WINDOW - 1) begin
              m_win = 8'd0;
              m_err = 8'd0;
            end else begin
              m_win++;
            end
          end
        end
        default: begin
          m_state     = 2'd0;
          m_quiet     = 8'd0;
          m_win       = 8'd0;
          m_err       = 8'd0;
          was_illegal = 1'b1;
        end
      endcase
      if (was_illegal) m_loss = 8'd0;
      else if (clr) m_loss = loss_ev ? 8'd1 : 8'd0;
      else if (loss_ev && m_loss != 8'd255) m_loss++;
      m_lost = loss_ev;
    end
  endtask

  // Drive one cycle of stimulus, queue the prediction, clock, then compare
  task automatic applyStimulus(input logic up, input logic down,
                               input logic clr, input logic sen,
                               input logic sin);
    expect_t e_push;
    expect_t e_pop;
    bus.i_up         = up;
    bus.i_down       = down;
    bus.i_clear_loss = clr;
    scan_en          = sen;
    scan_in          = sin;
    modelStep(up, down, clr, sen, sin);
    e_push.locked     = (m_state == 2'd2);
    e_push.lock_lost  = m_lost;
    e_push.loss_count = m_loss;
    e_push.state      = m_state;
    e_push.scan_out   = m_lost;
    sb_q.push_back(e_push);
    @(posedge clk_gen);
    #1;
    e_pop = sb_q.pop_front();
    checkOutput("locked",     64'(bus.o_locked),     64'(e_pop.locked));
    checkOutput("lock_lost",  64'(bus.o_lock_lost),  64'(e_pop.lock_lost));
    checkOutput("loss_count", 64'(bus.o_loss_count), 64'(e_pop.loss_count));
    checkOutput("state",      64'(bus.o_state),      64'(e_pop.state));
    checkOutput("scan_out",   64'(scan_out),         64'(e_pop.scan_out));
  endtask

  task automatic quietCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic downCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Assert reset between edges, check the reset values, release after an edge
  task automatic doReset();
    bus.i_up         = 1'b0;
    bus.i_down       = 1'b0;
    bus.i_clear_loss = 1'b0;
    scan_en          = 1'b0;
    scan_in          = 1'b0;
    rst_n            = 1'b1;
    #1;
    rst_n = 1'b0;
    modelReset();
    sb_q.delete();
    #2;
    checkOutput("rst_state",     64'(bus.o_state),      64'd0);
    checkOutput("rst_locked",    64'(bus.o_locked),     64'd0);
    checkOutput("rst_lock_lost", 64'(bus.o_lock_lost),  64'd0);
    checkOutput("rst_loss",      64'(bus.o_loss_count), 64'd0);
    checkOutput("rst_scan_out",  64'(scan_out),         64'd0);
    @(posedge clk_gen);
    #1;
    rst_n = 1'b1;
  endtask

  // Safety net in case the run ever stalls
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [34:0] pat_p;
    logic [34:0] pat_q;
    logic [34:0] pat_r;
    logic [34:0] got;

    // 1: lock after exactly 64 quiet cycles
    phase = "t1";
    doReset();
    quietCycles(LOCK_CYCLES - 1);
    checkOutput("not_yet_locked", 64'(bus.o_locked), 64'd0);
    quietCycles(1);
    checkOutput("locked_edge64", 64'(bus.o_locked), 64'd1);
    checkOutput("state_locked",  64'(bus.o_state),  64'd2);

    // 2: one up pulse restarts acquisition
    phase = "t2";
    doReset();
    quietCycles(LOCK_CYCLES - 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("back_unlocked", 64'(bus.o_state), 64'd0);
    quietCycles(LOCK_CYCLES - 1);
    checkOutput("acquiring",  64'(bus.o_state),  64'd1);
    checkOutput("not_locked", 64'(bus.o_locked), 64'd0);

    // 3: four errors spaced 5 apart inside one window lose lock
    phase = "t3";
    doReset();
    quietCycles(LOCK_CYCLES);
    for (int k = 0; k < 3; k++) begin
      downCycle();
      quietCycles(4);
    end
    checkOutput("still_locked", 64'(bus.o_locked), 64'd1);
    downCycle();
    checkOutput("lost_pulse",  64'(bus.o_lock_lost),  64'd1);
    checkOutput("unlocked",    64'(bus.o_locked),     64'd0);
    checkOutput("loss_one",    64'(bus.o_loss_count), 64'd1);
    quietCycles(1);
    checkOutput("pulse_single", 64'(bus.o_lock_lost), 64'd0);

    // 4: errors straddling a window boundary, then a loss on the last cycle
    phase = "t4";
    doReset();
    quietCycles(LOCK_CYCLES);
    quietCycles(9);
    downCycle();
    quietCycles(9);
    downCycle();
    quietCycles(11);
    downCycle();
    checkOutput("locked_w1_end", 64'(bus.o_locked), 64'd1);
    downCycle();
    downCycle();
    downCycle();
    checkOutput("locked_w2", 64'(bus.o_locked), 64'd1);
    quietCycles(WINDOW - 3);
    quietCycles(WINDOW - 4);
    downCycle();
    downCycle();
    downCycle();
    checkOutput("locked_w3_pre", 64'(bus.o_locked), 64'd1);
    downCycle();
    checkOutput("lost_on_cycle32", 64'(bus.o_lock_lost), 64'd1);

    // 5: loss counter saturation and clear colliding with a loss
    phase = "t5";
    doReset();
    for (int n = 0; n < 256; n++) begin
      quietCycles(LOCK_CYCLES);
      for (int k = 0; k < UNLOCK_ERRS; k++) downCycle();
    end
    checkOutput("saturated", 64'(bus.o_loss_count), 64'd255);
    quietCycles(LOCK_CYCLES);
    for (int k = 0; k < UNLOCK_ERRS - 1; k++) downCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("clear_with_loss", 64'(bus.o_loss_count), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("clear_only", 64'(bus.o_loss_count), 64'd0);

    // 6: scan shift with functional inputs active; they must be ignored
    phase = "t6";
    quietCycles(5);
    pat_p = 35'h6_9C3A_5B1D;
    pat_q = {2'd2, 8'd0, 8'd30, 8'd3, 8'd254, 1'b0};
    pat_r = {2'd3, 8'd7, 8'd9, 8'd2, 8'd5, 1'b0};
    got   = '0;
    for (int i = 0; i < 35; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, pat_p[i]);
    got[0] = scan_out;
    for (int i = 0; i < 34; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, pat_q[i]);
      got[i+1] = scan_out;
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, pat_q[34]);
    checkOutput("scan_pattern", 64'(got), 64'(pat_p));
    checkOutput("scan_state",   64'(bus.o_state),      64'd2);
    checkOutput("scan_loss",    64'(bus.o_loss_count), 64'd254);
    quietCycles(1);
    downCycle();
    checkOutput("resume_lost", 64'(bus.o_lock_lost),  64'd1);
    checkOutput("resume_loss", 64'(bus.o_loss_count), 64'd255);

    // Illegal state loaded by scan recovers to UNLOCKED
    for (int i = 0; i < 35; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, pat_r[i]);
    checkOutput("illegal_loaded", 64'(bus.o_state), 64'd3);
    quietCycles(1);
    checkOutput("illegal_recover", 64'(bus.o_state),      64'd0);
    checkOutput("illegal_cleared", 64'(bus.o_loss_count), 64'd0);
    quietCycles(LOCK_CYCLES);
    checkOutput("relock", 64'(bus.o_locked), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compare_count, mismatch_count);
    $finish;
  end

endmodule
